// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared definitions for the cache<->memory arbiter: FSM states, default sizing,
// requester port indices and the SRAM control payload.
package mem_arbiter_ctrl_pkg;

  localparam int unsigned NPORTS_DEF      = 4;
  localparam int unsigned BLEN_DEF        = 4;
  localparam int unsigned WAIT_CYCLES_DEF = 2;

  localparam int unsigned DMA = 0;
  localparam int unsigned IC  = 1;
  localparam int unsigned DC  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  typedef struct packed {
    logic sel;
    logic rwbar;
    logic ready;
  } mem_ctl_t;

  localparam mem_ctl_t CTL_IDLE = '{sel: 1'b0, rwbar: 1'b1, ready: 1'b0};

  // Counter width for a range of n values, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_prio_enc.sv
// Fixed-priority one-hot encoder: the highest set request index wins.
module mem_arbiter_ctrl_prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant_c
);

  always_comb begin
    o_grant_c = '0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) begin
        o_grant_c    = '0;
        o_grant_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Single-port SRAM arbiter for cache line fills / write-backs: fixed priority,
// non-preemptive bursts of BLEN words, WAIT_CYCLES wait states per word.
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned NPORTS      = NPORTS_DEF,
  parameter int unsigned BLEN        = BLEN_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              skip_wait,
  input  logic [NPORTS-1:0] read_request,
  input  logic [NPORTS-1:0] write_request,
  output logic [NPORTS-1:0] grant,
  output logic              memory_sel,
  output logic              rwbar,
  output logic              ready
);

  localparam int unsigned WW = cnt_width(WAIT_CYCLES + 1);
  localparam int unsigned BW = cnt_width(BLEN);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [NPORTS-1:0] r_grant;
  logic [NPORTS-1:0] w_grant_nxt;
  mem_ctl_t          r_ctl;
  mem_ctl_t          w_ctl_nxt;
  logic [WW-1:0]     r_wcnt;
  logic [WW-1:0]     w_wcnt_nxt;
  logic [BW-1:0]     r_bcnt;
  logic [BW-1:0]     w_bcnt_nxt;

  logic [NPORTS-1:0] w_req;
  logic [NPORTS-1:0] w_pick;
  logic [WW-1:0]     w_wlim;
  logic [WW:0]       w_wcnt_inc;
  logic              w_owner_live;
  logic              w_last_done;

  assign w_req        = read_request | write_request;
  assign w_wlim       = skip_wait ? '0 : WW'(WAIT_CYCLES);
  assign w_wcnt_inc   = {1'b0, r_wcnt} + (WW+1)'(1);
  assign w_owner_live = |(w_req & r_grant);
  assign w_last_done  = r_ctl.ready && (r_bcnt == BW'(BLEN - 1));

  mem_arbiter_ctrl_prio_enc #(.N(NPORTS)) u_prio_enc (
    .i_req     (w_req),
    .o_grant_c (w_pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|w_req) w_state_nxt = ST_ACCESS;
      ST_ACCESS:  if (!w_owner_live || w_last_done) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Next registered outputs; the word a cycle presents is decided one edge earlier
  always_comb begin
    w_grant_nxt = '0;
    w_ctl_nxt   = CTL_IDLE;
    w_wcnt_nxt  = '0;
    w_bcnt_nxt  = '0;
    if (w_state_nxt == ST_ACCESS) begin
      w_ctl_nxt.sel = 1'b1;
      if (r_state == ST_IDLE) begin
        w_grant_nxt     = w_pick;
        w_ctl_nxt.rwbar = ~|(write_request & w_pick);
        w_ctl_nxt.ready = (w_wlim == '0);
      end else begin
        w_grant_nxt     = r_grant;
        w_ctl_nxt.rwbar = r_ctl.rwbar;
        if (r_ctl.ready) begin
          w_bcnt_nxt      = r_bcnt + BW'(1);
          w_ctl_nxt.ready = (w_wlim == '0);
        end else begin
          w_bcnt_nxt      = r_bcnt;
          w_wcnt_nxt      = (r_wcnt < w_wlim) ? w_wcnt_inc[WW-1:0] : r_wcnt;
          w_ctl_nxt.ready = (w_wcnt_inc >= {1'b0, w_wlim});
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant <= '0;
      r_ctl   <= CTL_IDLE;
      r_wcnt  <= '0;
      r_bcnt  <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_ctl   <= w_ctl_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  assign grant      = r_grant;
  assign memory_sel = r_ctl.sel;
  assign rwbar      = r_ctl.rwbar;
  assign ready      = r_ctl.ready;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: directed protocol scenarios plus randomized
// requesters, all checked against a burst-schedule reference model.
module tb_mem_arbiter_ctrl;

  localparam int NP = 4;
  localparam int BL = 4;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          skip_wait = 1'b0;
  logic [NP-1:0] read_request = '0;
  logic [NP-1:0] write_request = '0;
  logic [NP-1:0] grant;
  logic          memory_sel;
  logic          rwbar;
  logic          ready;

  mem_arbiter_ctrl #(.NPORTS(NP), .BLEN(BL), .WAIT_CYCLES(WC)) dut (
    .clk           (clk),
    .rst           (rst),
    .skip_wait     (skip_wait),
    .read_request  (read_request),
    .write_request (write_request),
    .grant         (grant),
    .memory_sel    (memory_sel),
    .rwbar         (rwbar),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a burst granted at cycle g with wait W produces word k ready
  // at g + (k+1)*(W+1) - 1, releases one cycle after the last word (or after the
  // owner drops), and the next decision is taken the cycle after release.
  int            t = 0;
  int            m_owner = -1;
  int            m_g = 0;
  int            m_w = 0;
  int            m_rel = -100;
  logic          m_dir = 1'b1;
  bit            m_ab = 1'b0;
  int            rdy_cnt = 0;
  logic [NP-1:0] prev_grant = '0;
  logic [NP-1:0] prev_req = '0;

  int            t0 = 0;
  logic [NP-1:0] h_grant [0:63];
  logic          h_sel   [0:63];
  logic          h_rw    [0:63];
  logic          h_rdy   [0:63];

  function automatic logic [6:0] expected_out();
    logic [NP-1:0] g;
    logic          r;
    if (m_owner >= 0 && t >= m_g && t < m_rel) begin
      g = 4'b0001 << m_owner;
      r = ((t - m_g + 1) % (m_w + 1)) == 0;
      return {g, 1'b1, m_dir, r};
    end
    return 7'b0000_0_1_0;
  endfunction

  task automatic sample_and_model();
    logic [NP-1:0] req;
    int            idx;
    int            p;
    req = read_request | write_request;
    check("outputs", {grant, memory_sel, rwbar, ready}, expected_out());
    check("grant_onehot0", 32'($onehot0(grant)), 1);
    check("sel_vs_grant", memory_sel, |grant);
    check("ready_needs_sel", ready & ~memory_sel, 0);
    if (grant != '0 && prev_grant == '0) begin
      check("grant_to_requester", |(grant & prev_req), 1);
      rdy_cnt = 0;
    end
    if (ready) rdy_cnt++;
    if (prev_grant != '0 && grant == '0 && !m_ab) check("burst_readys", rdy_cnt, BL);
    prev_grant = grant;

    idx = t - t0;
    if (idx >= 0 && idx < 64) begin
      h_grant[idx] = grant;
      h_sel[idx]   = memory_sel;
      h_rw[idx]    = rwbar;
      h_rdy[idx]   = ready;
    end

    if (m_owner >= 0 && t >= m_g && t < m_rel) begin
      if (!read_request[m_owner] && !write_request[m_owner]) begin
        if (t + 1 < m_rel) m_ab = 1'b1;
        m_rel = t + 1;
      end
    end else if (t >= m_rel + 1 && req != '0) begin
      p = 0;
      for (int i = 0; i < NP; i++) if (req[i]) p = i;
      m_owner = p;
      m_g     = t + 1;
      m_w     = skip_wait ? 0 : WC;
      m_rel   = m_g + BL * (m_w + 1);
      m_dir   = ~write_request[p];
      m_ab    = 1'b0;
    end
    prev_req = req;
    t++;
  endtask

  task automatic cyc(input logic [NP-1:0] rd, input logic [NP-1:0] wr, input logic sk);
    @(posedge clk);
    #1;
    read_request  = rd;
    write_request = wr;
    skip_wait     = sk;
    @(negedge clk);
    sample_and_model();
  endtask

  task automatic run(input logic [NP-1:0] rd, input logic [NP-1:0] wr, input logic sk,
                     input int n);
    for (int i = 0; i < n; i++) cyc(rd, wr, sk);
  endtask

  task automatic begin_test();
    t0 = t;
    for (int i = 0; i < 64; i++) begin
      h_grant[i] = '0;
      h_sel[i]   = 1'b0;
      h_rw[i]    = 1'b0;
      h_rdy[i]   = 1'b0;
    end
  endtask

  function automatic logic [31:0] ready_vec(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = h_rdy[i];
    return v;
  endfunction

  logic [NP-1:0] rd_v;
  logic [NP-1:0] wr_v;
  bit            got_g [NP];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    check("reset_outputs", {grant, memory_sel, rwbar, ready}, 7'h02);
    @(negedge clk);
    rst = 1'b1;
    run('0, '0, 1'b0, 3);

    // single read burst with wait states
    begin_test();
    run(4'b0010, '0, 1'b0, 13);
    run('0, '0, 1'b0, 3);
    check("t1_ready_cycles", ready_vec(16), 32'h1248);
    check("t1_grant_c1", h_grant[1], 4'b0010);
    check("t1_rwbar_c1", h_rw[1], 1);
    check("t1_release_c13", {h_grant[13], h_sel[13]}, 0);

    // write beats read, then read after one dead cycle
    run('0, '0, 1'b0, 2);
    begin_test();
    run(4'b0010, 4'b0100, 1'b0, 13);
    run(4'b0010, '0, 1'b0, 14);
    run('0, '0, 1'b0, 3);
    check("t2_grant_c1", h_grant[1], 4'b0100);
    check("t2_rwbar_c1", h_rw[1], 0);
    check("t2_dead_c13_c14", {h_grant[13], h_grant[14]}, 0);
    check("t2_grant_c15", h_grant[15], 4'b0010);
    check("t2_rwbar_c15", h_rw[15], 1);

    // skip_wait: one word per cycle
    run('0, '0, 1'b1, 2);
    begin_test();
    run(4'b0001, '0, 1'b1, 5);
    run('0, '0, 1'b1, 3);
    check("t3_ready_cycles", ready_vec(8), 32'h1E);
    check("t3_grant_c1", h_grant[1], 4'b0001);
    check("t3_sel_c5", h_sel[5], 0);
    run('0, '0, 1'b0, 2);

    // no preemption by a higher-priority port
    begin_test();
    run(4'b0010, '0, 1'b0, 5);
    run(4'b0110, '0, 1'b0, 8);
    run(4'b0100, '0, 1'b0, 14);
    run('0, '0, 1'b0, 3);
    check("t4_grant_c12", h_grant[12], 4'b0010);
    check("t4_dead_c13_c14", {h_grant[13], h_grant[14]}, 0);
    check("t4_grant_c15", h_grant[15], 4'b0100);

    // owner abort after first word
    begin_test();
    run(4'b0010, '0, 1'b0, 5);
    run('0, '0, 1'b0, 5);
    check("t5_ready_cycles", ready_vec(10), 32'h8);
    check("t5_grant_c5", h_grant[5], 4'b0010);
    check("t5_release_c6", {h_grant[6], h_sel[6]}, 0);

    // asynchronous reset mid-burst
    run('0, '0, 1'b0, 2);
    run('0, 4'b1000, 1'b0, 5);
    check("t5_in_burst", grant, 4'b1000);
    #2;
    rst = 1'b0;
    read_request  = '0;
    write_request = '0;
    #1;
    check("t5_async_reset", {grant, memory_sel, rwbar, ready}, 7'h02);
    @(negedge clk);
    check("t5_reset_held", {grant, memory_sel, rwbar, ready}, 7'h02);
    rst        = 1'b1;
    m_owner    = -1;
    m_rel      = -100;
    m_ab       = 1'b0;
    prev_grant = '0;
    prev_req   = '0;
    rdy_cnt    = 0;
    run('0, '0, 1'b0, 3);

    // randomized requesters, skip_wait changed only between quiet gaps
    rd_v = '0;
    wr_v = '0;
    for (int i = 0; i < NP; i++) got_g[i] = 1'b0;
    for (int seg = 0; seg < 10; seg++) begin
      logic sk;
      sk = 1'($urandom_range(0, 1));
      rd_v = '0;
      wr_v = '0;
      for (int i = 0; i < NP; i++) got_g[i] = 1'b0;
      run('0, '0, sk, 4);
      for (int c = 0; c < 1000; c++) begin
        for (int p = 0; p < NP; p++) begin
          if (!(rd_v[p] | wr_v[p])) begin
            got_g[p] = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
              case ($urandom_range(0, 2))
                0:       rd_v[p] = 1'b1;
                1:       wr_v[p] = 1'b1;
                default: begin rd_v[p] = 1'b1; wr_v[p] = 1'b1; end
              endcase
            end
          end else begin
            if (grant[p]) got_g[p] = 1'b1;
            if (got_g[p] && !grant[p]) begin
              rd_v[p] = 1'b0;
              wr_v[p] = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
              rd_v[p] = 1'b0;
              wr_v[p] = 1'b0;
            end else if (grant[p] && $urandom_range(0, 11) == 0) begin
              rd_v[p] = ~rd_v[p];
              wr_v[p] = ~rd_v[p];
            end
          end
        end
        cyc(rd_v, wr_v, sk);
      end
    end
    run('0, '0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
